// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory controller between the fetch unit
// (word reads only) and the load/store unit. One requester is granted at a time,
// the controller request is held stable until mem_ready, and the result is
// returned to the granted requester as a registered one-cycle ready pulse.
// A fetch flush turns an outstanding fetch into a drain that discards the result.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  i_valid,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_clear,
   output logic                  i_ready,
   output logic [31:0]           i_data,
   input  logic                  d_valid,
   input  logic                  d_wr,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [1:0]            d_len,
   input  logic [31:0]           d_wdata,
   output logic                  d_ready,
   output logic [31:0]           d_rdata,
   output logic                  mem_valid,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [1:0]            mem_len,
   output logic [31:0]           mem_data,
   input  logic                  mem_ready,
   input  logic [31:0]           mem_res
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic                    last_d_r, last_d_nxt_s;     // 1: data was granted last
   logic                    req_i_s, req_d_s, grant_i_s, grant_d_s;

   logic                    mem_valid_r, mem_valid_nxt_s;
   logic                    mem_wr_r, mem_wr_nxt_s;
   logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_nxt_s;
   logic [1:0]              mem_len_r, mem_len_nxt_s;
   logic [31:0]             mem_data_r, mem_data_nxt_s;
   logic                    i_ready_r, i_ready_nxt_s;
   logic [31:0]             i_data_r, i_data_nxt_s;
   logic                    d_ready_r, d_ready_nxt_s;
   logic [31:0]             d_rdata_r, d_rdata_nxt_s;

   // Request qualification and round-robin choice between the two requesters.
   always_comb begin
      // A requester whose ready pulse is out this cycle is still showing its old
      // request, so it is not eligible; a flush cycle suppresses the fetch request.
      req_i_s   = i_valid & ~i_clear & ~i_ready_r;
      req_d_s   = d_valid & ~d_ready_r;
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (req_i_s && req_d_s) begin
         grant_d_s = ~last_d_r;
         grant_i_s = last_d_r;
      end else begin
         grant_d_s = req_d_s;
         grant_i_s = req_i_s;
      end
   end

   // State register; rdy_in low freezes the machine.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r <= ST_IDLE;
      end else if (rdy_in) begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_d_s) begin
               state_nxt_s = ST_BUSY_D;
            end else if (grant_i_s) begin
               state_nxt_s = ST_BUSY_I;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY_I: begin
            if (mem_ready) begin
               state_nxt_s = ST_IDLE;
            end else if (i_clear) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_BUSY_I;
            end
         end
         ST_BUSY_D, ST_DRAIN: begin
            if (mem_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and latched request.
   always_comb begin
      last_d_nxt_s    = last_d_r;
      mem_wr_nxt_s    = mem_wr_r;
      mem_addr_nxt_s  = mem_addr_r;
      mem_len_nxt_s   = mem_len_r;
      mem_data_nxt_s  = mem_data_r;
      i_data_nxt_s    = i_data_r;
      d_rdata_nxt_s   = d_rdata_r;
      i_ready_nxt_s   = 1'b0;
      d_ready_nxt_s   = 1'b0;
      mem_valid_nxt_s = (state_nxt_s != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            if (grant_d_s) begin
               last_d_nxt_s   = 1'b1;
               mem_wr_nxt_s   = d_wr;
               mem_addr_nxt_s = d_addr;
               mem_len_nxt_s  = d_len;
               mem_data_nxt_s = d_wdata;
            end else if (grant_i_s) begin
               last_d_nxt_s   = 1'b0;
               mem_wr_nxt_s   = 1'b0;
               mem_addr_nxt_s = i_addr;
               mem_len_nxt_s  = 2'b10;
               mem_data_nxt_s = 32'h0000_0000;
            end else begin
               last_d_nxt_s   = last_d_r;
            end
         end
         ST_BUSY_I: begin
            // A flush landing on the completion cycle discards the result.
            if (mem_ready && !i_clear) begin
               i_ready_nxt_s = 1'b1;
               i_data_nxt_s  = mem_res;
            end else begin
               i_ready_nxt_s = 1'b0;
            end
         end
         ST_BUSY_D: begin
            if (mem_ready) begin
               d_ready_nxt_s = 1'b1;
               d_rdata_nxt_s = mem_wr_r ? 32'h0000_0000 : mem_res;
            end else begin
               d_ready_nxt_s = 1'b0;
            end
         end
         ST_DRAIN: begin
            i_ready_nxt_s = 1'b0;
         end
         default: begin
            i_ready_nxt_s = 1'b0;
         end
      endcase
   end

   // Output and latched-request registers; rdy_in low holds everything.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_d_r    <= ~DATA_FIRST;
         mem_valid_r <= 1'b0;
         mem_wr_r    <= 1'b0;
         mem_addr_r  <= {ADDR_WIDTH{1'b0}};
         mem_len_r   <= 2'b00;
         mem_data_r  <= 32'h0000_0000;
         i_ready_r   <= 1'b0;
         i_data_r    <= 32'h0000_0000;
         d_ready_r   <= 1'b0;
         d_rdata_r   <= 32'h0000_0000;
      end else if (rdy_in) begin
         last_d_r    <= last_d_nxt_s;
         mem_valid_r <= mem_valid_nxt_s;
         mem_wr_r    <= mem_wr_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_len_r   <= mem_len_nxt_s;
         mem_data_r  <= mem_data_nxt_s;
         i_ready_r   <= i_ready_nxt_s;
         i_data_r    <= i_data_nxt_s;
         d_ready_r   <= d_ready_nxt_s;
         d_rdata_r   <= d_rdata_nxt_s;
      end
   end

   assign mem_valid = mem_valid_r;
   assign mem_wr    = mem_wr_r;
   assign mem_addr  = mem_addr_r;
   assign mem_len   = mem_len_r;
   assign mem_data  = mem_data_r;
   assign i_ready   = i_ready_r;
   assign i_data    = i_data_r;
   assign d_ready   = d_ready_r;
   assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors, hand-written corner sequences and a
// randomized run against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        i_valid, i_clear, i_ready;
   logic [31:0] i_addr, i_data;
   logic        d_valid, d_wr, d_ready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [1:0]  d_len;
   logic        mem_valid, mem_wr, mem_ready;
   logic [31:0] mem_addr, mem_data, mem_res;
   logic [1:0]  mem_len;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_FIRST(1'b1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .i_valid(i_valid), .i_addr(i_addr), .i_clear(i_clear),
      .i_ready(i_ready), .i_data(i_data),
      .d_valid(d_valid), .d_wr(d_wr), .d_addr(d_addr), .d_len(d_len),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_len(mem_len), .mem_data(mem_data),
      .mem_ready(mem_ready), .mem_res(mem_res)
   );

   typedef struct {
      logic rst, rdy, iv; logic [31:0] ia; logic ic;
      logic dv, dw; logic [31:0] da; logic [1:0] dl; logic [31:0] dd;
      logic mr; logic [31:0] mres;
      logic emv, emwr; logic [31:0] ema; logic [1:0] eml; logic [31:0] emd;
      logic eir; logic [31:0] eid; logic edr; logic [31:0] edd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(
      input logic rst, rdy, iv, input logic [31:0] ia, input logic ic,
      input logic dv, dw, input logic [31:0] da, input logic [1:0] dl,
      input logic [31:0] dd, input logic mr, input logic [31:0] mres,
      input logic emv, emwr, input logic [31:0] ema, input logic [1:0] eml,
      input logic [31:0] emd, input logic eir, input logic [31:0] eid,
      input logic edr, input logic [31:0] edd);
      vec_t r;
      r.rst = rst; r.rdy = rdy; r.iv = iv; r.ia = ia; r.ic = ic;
      r.dv = dv; r.dw = dw; r.da = da; r.dl = dl; r.dd = dd;
      r.mr = mr; r.mres = mres;
      r.emv = emv; r.emwr = emwr; r.ema = ema; r.eml = eml; r.emd = emd;
      r.eir = eir; r.eid = eid; r.edr = edr; r.edd = edd;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic emv, emwr,
                            input logic [31:0] ema, input logic [1:0] eml,
                            input logic [31:0] emd, input logic eir,
                            input logic [31:0] eid, input logic edr,
                            input logic [31:0] edd);
      chk({tag, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, emv});
      chk({tag, ".mem_wr"},    {31'd0, mem_wr},    {31'd0, emwr});
      chk({tag, ".mem_addr"},  mem_addr, ema);
      chk({tag, ".mem_len"},   {30'd0, mem_len},   {30'd0, eml});
      chk({tag, ".mem_data"},  mem_data, emd);
      chk({tag, ".i_ready"},   {31'd0, i_ready},   {31'd0, eir});
      chk({tag, ".i_data"},    i_data, eid);
      chk({tag, ".d_ready"},   {31'd0, d_ready},   {31'd0, edr});
      chk({tag, ".d_rdata"},   d_rdata, edd);
   endtask

   task automatic step;
      @(posedge clk_in);
      #1;
   endtask

   task automatic quiet;
      rst_in = 1'b0; rdy_in = 1'b1; i_valid = 1'b0; i_addr = 32'h0; i_clear = 1'b0;
      d_valid = 1'b0; d_wr = 1'b0; d_addr = 32'h0; d_len = 2'd0; d_wdata = 32'h0;
      mem_ready = 1'b0; mem_res = 32'h0;
   endtask

   // Reference model state for the randomized run.
   logic        m_busy, m_who_d, m_dropped, m_last_d;
   logic        m_wr; logic [31:0] m_addr, m_data; logic [1:0] m_len;
   logic        m_ir, m_dr; logic [31:0] m_id, m_dd;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic want_i, want_d, n_ir, n_dr;
      quiet();
      rst_in = 1'b1;
      step(); step();
      check_all("reset", 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      rst_in = 1'b0;

      // ---------------- table-driven vectors ----------------
      // fetch only, 4-cycle controller latency
      for (int k = 0; k < 4; k++)
         vecs.push_back(v(0,1,1,32'h1000,0, 0,0,0,0,0, 0,0,
                          1,0,32'h1000,2,0, 0,0, 0,0));
      vecs.push_back(v(0,1,1,32'h1000,0, 0,0,0,0,0, 1,32'hDEADBEEF,
                       0,0,32'h1000,2,0, 1,32'hDEADBEEF, 0,0));
      vecs.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0,
                       0,0,32'h1000,2,0, 0,32'hDEADBEEF, 0,0));
      // synchronous-looking reset row, then contention right after reset
      vecs.push_back(v(1,1,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0));
      vecs.push_back(v(0,1,1,32'h1004,0, 1,0,32'h2000,0,0, 0,0,
                       1,0,32'h2000,0,0, 0,0, 0,0));
      vecs.push_back(v(0,1,1,32'h1004,0, 1,0,32'h2000,0,0, 1,32'hAB,
                       0,0,32'h2000,0,0, 0,0, 1,32'hAB));
      vecs.push_back(v(0,1,1,32'h1004,0, 0,0,0,0,0, 0,0,
                       1,0,32'h1004,2,0, 0,0, 0,32'hAB));
      vecs.push_back(v(0,1,1,32'h1004,0, 0,0,0,0,0, 1,32'h11223344,
                       0,0,32'h1004,2,0, 1,32'h11223344, 0,32'hAB));
      vecs.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0,
                       0,0,32'h1004,2,0, 0,32'h11223344, 0,32'hAB));
      // round robin with both continuously valid: D, I, D, I
      vecs.push_back(v(0,1,1,32'h100,0, 1,1,32'h3000,2,32'hCAFEF00D, 0,0,
                       1,1,32'h3000,2,32'hCAFEF00D, 0,32'h11223344, 0,32'hAB));
      vecs.push_back(v(0,1,1,32'h100,0, 1,1,32'h3000,2,32'hCAFEF00D, 1,32'h5555,
                       0,1,32'h3000,2,32'hCAFEF00D, 0,32'h11223344, 1,0));
      vecs.push_back(v(0,1,1,32'h100,0, 1,1,32'h3004,2,32'h12345678, 0,0,
                       1,0,32'h100,2,0, 0,32'h11223344, 0,0));
      vecs.push_back(v(0,1,1,32'h100,0, 1,1,32'h3004,2,32'h12345678, 1,32'hA5A5A5A5,
                       0,0,32'h100,2,0, 1,32'hA5A5A5A5, 0,0));
      vecs.push_back(v(0,1,1,32'h104,0, 1,1,32'h3004,2,32'h12345678, 0,0,
                       1,1,32'h3004,2,32'h12345678, 0,32'hA5A5A5A5, 0,0));
      vecs.push_back(v(0,1,1,32'h104,0, 1,1,32'h3004,2,32'h12345678, 1,32'h9999,
                       0,1,32'h3004,2,32'h12345678, 0,32'hA5A5A5A5, 1,0));
      vecs.push_back(v(0,1,1,32'h104,0, 0,0,0,0,0, 0,0,
                       1,0,32'h104,2,0, 0,32'hA5A5A5A5, 0,0));
      vecs.push_back(v(0,1,1,32'h104,0, 0,0,0,0,0, 1,32'h0BADCAFE,
                       0,0,32'h104,2,0, 1,32'h0BADCAFE, 0,0));
      vecs.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0,
                       0,0,32'h104,2,0, 0,32'h0BADCAFE, 0,0));

      for (int k = 0; k < vecs.size(); k++) begin
         rst_in = vecs[k].rst; rdy_in = vecs[k].rdy;
         i_valid = vecs[k].iv; i_addr = vecs[k].ia; i_clear = vecs[k].ic;
         d_valid = vecs[k].dv; d_wr = vecs[k].dw; d_addr = vecs[k].da;
         d_len = vecs[k].dl; d_wdata = vecs[k].dd;
         mem_ready = vecs[k].mr; mem_res = vecs[k].mres;
         step();
         check_all($sformatf("vec%0d", k), vecs[k].emv, vecs[k].emwr, vecs[k].ema,
                   vecs[k].eml, vecs[k].emd, vecs[k].eir, vecs[k].eid,
                   vecs[k].edr, vecs[k].edd);
      end
      quiet();

      // ---------------- flush two cycles into a fetch, pending store ----------------
      i_valid = 1'b1; i_addr = 32'h400; step();
      check_all("fl_grant", 1, 0, 32'h400, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      d_valid = 1'b1; d_wr = 1'b1; d_addr = 32'h30000; d_len = 2'd0; d_wdata = 32'h41;
      step();
      check_all("fl_busy", 1, 0, 32'h400, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      i_clear = 1'b1; step();
      check_all("fl_drain", 1, 0, 32'h400, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      i_clear = 1'b0; i_valid = 1'b0; step();
      check_all("fl_hold", 1, 0, 32'h400, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      mem_ready = 1'b1; mem_res = 32'hFFFFFFFF; step();
      check_all("fl_done", 0, 0, 32'h400, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      mem_ready = 1'b0; step();
      check_all("fl_store", 1, 1, 32'h30000, 0, 32'h41, 0, 32'h0BADCAFE, 0, 0);
      mem_ready = 1'b1; mem_res = 32'h0; step();
      check_all("fl_store_done", 0, 1, 32'h30000, 0, 32'h41, 0, 32'h0BADCAFE, 1, 0);
      quiet(); step();

      // ---------------- flush coincident with mem_ready ----------------
      i_valid = 1'b1; i_addr = 32'h500; step();
      check_all("fc_grant", 1, 0, 32'h500, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      i_clear = 1'b1; mem_ready = 1'b1; mem_res = 32'h77; step();
      check_all("fc_done", 0, 0, 32'h500, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      quiet(); step();
      check_all("fc_after", 0, 0, 32'h500, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      i_valid = 1'b1; i_addr = 32'h600; i_clear = 1'b1; step();
      check_all("fc_idle_clear", 0, 0, 32'h500, 2, 0, 0, 32'h0BADCAFE, 0, 0);
      quiet(); step();

      // ---------------- rdy_in low for 3 cycles mid load ----------------
      d_valid = 1'b1; d_addr = 32'h700; d_len = 2'd1; step();
      check_all("rdy_grant", 1, 0, 32'h700, 1, 0, 0, 32'h0BADCAFE, 0, 0);
      rdy_in = 1'b0; mem_ready = 1'b1; mem_res = 32'h1234;
      for (int k = 0; k < 3; k++) begin
         step();
         check_all($sformatf("rdy_low%0d", k), 1, 0, 32'h700, 1, 0, 0, 32'h0BADCAFE, 0, 0);
         mem_ready = 1'b0;
      end
      rdy_in = 1'b1; step();
      check_all("rdy_back", 1, 0, 32'h700, 1, 0, 0, 32'h0BADCAFE, 0, 0);
      mem_ready = 1'b1; mem_res = 32'hBEEF; step();
      check_all("rdy_done", 0, 0, 32'h700, 1, 0, 0, 32'h0BADCAFE, 1, 32'hBEEF);
      quiet(); step();

      // ---------------- asynchronous reset mid-transaction ----------------
      i_valid = 1'b1; i_addr = 32'h800; step();
      check_all("ar_grant", 1, 0, 32'h800, 2, 0, 0, 32'h0BADCAFE, 0, 32'hBEEF);
      #2 rst_in = 1'b1;
      #1 check_all("ar_async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_in);
      i_valid = 1'b0; mem_ready = 1'b1; mem_res = 32'h5A5A;
      @(negedge clk_in);
      rst_in = 1'b0; mem_ready = 1'b0;
      step();
      check_all("ar_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---------------- randomized run against the reference model ----------------
      quiet(); rst_in = 1'b1; step(); rst_in = 1'b0;
      m_busy = 0; m_who_d = 0; m_dropped = 0; m_last_d = 1'b0;
      m_wr = 0; m_addr = 0; m_data = 0; m_len = 0;
      m_ir = 0; m_dr = 0; m_id = 0; m_dd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rdy_in  = ($urandom_range(0, 9) != 0);
         i_clear = rdy_in && ($urandom_range(0, 15) == 0);
         if (m_ir || i_clear) i_valid = 1'b0;
         else if (!i_valid && $urandom_range(0, 2) == 0) begin
            i_valid = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (m_dr) d_valid = 1'b0;
         else if (!d_valid && $urandom_range(0, 2) == 0) begin
            d_valid = 1'b1; d_wr = $urandom_range(0, 1); d_addr = $urandom;
            d_len = $urandom_range(0, 3); d_wdata = $urandom;
         end
         mem_ready = ($urandom_range(0, 2) == 0);
         mem_res   = $urandom;
         // model: one clock of arbiter behaviour, derived from its rules
         if (rdy_in) begin
            n_ir = 1'b0; n_dr = 1'b0;
            if (m_busy) begin
               if (mem_ready) begin
                  m_busy = 1'b0;
                  if (m_who_d) begin
                     n_dr = 1'b1; m_dd = m_wr ? 32'h0 : mem_res;
                  end else if (!m_dropped && !i_clear) begin
                     n_ir = 1'b1; m_id = mem_res;
                  end
                  m_dropped = 1'b0;
               end else if (!m_who_d && i_clear) m_dropped = 1'b1;
            end else begin
               want_i = i_valid && !i_clear && !m_ir;
               want_d = d_valid && !m_dr;
               if (want_d && (!want_i || !m_last_d)) begin
                  m_busy = 1; m_who_d = 1; m_last_d = 1;
                  m_wr = d_wr; m_addr = d_addr; m_len = d_len; m_data = d_wdata;
               end else if (want_i) begin
                  m_busy = 1; m_who_d = 0; m_last_d = 0;
                  m_wr = 0; m_addr = i_addr; m_len = 2'd2; m_data = 32'h0;
               end
            end
            m_ir = n_ir; m_dr = n_dr;
         end
         step();
         check_all($sformatf("rnd%0d", cyc), m_busy, m_wr, m_addr, m_len, m_data,
                   m_ir, m_id, m_dr, m_dd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
